// File: rtl/multi_mode_time_counter_pkg.sv
// Shared field widths, moduli and mode encoding for the time counter.
package time_pkg;
  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;

  typedef enum logic {
    MODE_CLOCK = 1'b0,
    MODE_TIMER = 1'b1
  } mode_e;
endpackage

// File: rtl/multi_mode_time_counter_field.sv
// One wrapping modulo-MOD up/down field with load priority and carry/borrow out.
module mod_n_field #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] val,
  output logic         co
);
  localparam logic [W-1:0] MAX = W'(MOD - 1);
  localparam logic [W-1:0] ONE = W'(1);

  // co flags the step that wraps this field, i.e. the carry/borrow into the next one
  assign co = en && !load && (dec ? (val == '0) : (val == MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      val <= '0;
    else if (load) val <= load_val;
    else if (en)   val <= dec ? ((val == '0) ? MAX : val - ONE)
                              : ((val == MAX) ? '0 : val + ONE);
  end
endmodule

// File: rtl/multi_mode_time_counter.sv
// HH:MM:SS counter: clock (up), timer (down) and per-field set modes, plus alarm.
module multi_mode_time_counter
  import time_pkg::*;
#(
  parameter int HOURS_MOD = 24,
  parameter int PRESET_H  = 23,
  parameter int PRESET_M  = 59,
  parameter int PRESET_S  = 50
) (
  input  logic       clk_1Hz,
  input  logic       rst,
  input  logic       mode,
  input  logic       set_en,
  input  logic [2:0] set_sel,
  input  logic       set_dec,
  input  logic       preset_load,
  input  logic       alarm_en,
  input  logic [4:0] alarm_h,
  input  logic [5:0] alarm_m,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       day_increment,
  output logic       timer_done,
  output logic       alarm_hit,
  output logic [2:0] set_led
);
  logic at_zero, clk_run, tmr_run, cnt_dec;
  logic sec_en, min_en, hr_en;
  logic sec_co, min_co, hr_co;
  logic [4:0] h_nxt;
  logic [5:0] m_nxt;

  assign at_zero = (hours == '0) && (minutes == '0) && (seconds == '0);
  assign clk_run = !preset_load && !set_en && (mode == MODE_CLOCK);
  assign tmr_run = !preset_load && !set_en && (mode == MODE_TIMER) && !at_zero;

  // In set mode each field steps on its own select; otherwise carries chain upward
  assign cnt_dec = set_en ? set_dec : (mode == MODE_TIMER);
  assign sec_en  = set_en ? set_sel[0] : (clk_run || tmr_run);
  assign min_en  = set_en ? set_sel[1] : sec_co;
  assign hr_en   = set_en ? set_sel[2] : min_co;

  mod_n_field #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
    .clk(clk_1Hz), .rst(rst), .en(sec_en), .dec(cnt_dec), .load(preset_load),
    .load_val(SEC_W'(PRESET_S)), .val(seconds), .co(sec_co));

  mod_n_field #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
    .clk(clk_1Hz), .rst(rst), .en(min_en), .dec(cnt_dec), .load(preset_load),
    .load_val(MIN_W'(PRESET_M)), .val(minutes), .co(min_co));

  mod_n_field #(.MOD(HOURS_MOD), .W(HOUR_W)) u_hr (
    .clk(clk_1Hz), .rst(rst), .en(hr_en), .dec(cnt_dec), .load(preset_load),
    .load_val(HOUR_W'(PRESET_H)), .val(hours), .co(hr_co));

  // Alarm only fires on a seconds wrap, so the post-step time is :00 by construction
  assign m_nxt = min_co ? '0 : minutes + 6'd1;
  assign h_nxt = hr_co ? '0 : (min_co ? hours + 5'd1 : hours);

  always_ff @(posedge clk_1Hz or negedge rst) begin
    if (!rst) begin
      day_increment <= 1'b0;
      timer_done    <= 1'b0;
      alarm_hit     <= 1'b0;
      set_led       <= '0;
    end else begin
      day_increment <= clk_run && hr_co;
      timer_done    <= !preset_load && !set_en && (mode == MODE_TIMER) && at_zero;
      alarm_hit     <= alarm_en && clk_run && sec_co &&
                       (h_nxt == alarm_h) && (m_nxt == alarm_m);
      set_led       <= set_sel & {3{set_en}};
    end
  end
endmodule

// File: doc/multi_mode_time_counter.md
MULTI_MODE_TIME_COUNTER -- requirements
Module: multi_mode_time_counter

Interface
REQ-001 Parameter HOURS_MOD, default 24, hour-field modulus; legal range 2..24.
REQ-002 Parameter PRESET_H, default 23, hour value loaded by preset_load.
REQ-003 Parameter PRESET_M, default 59, minute value loaded by preset_load.
REQ-004 Parameter PRESET_S, default 50, second value loaded by preset_load.
REQ-005 clk_1Hz  in  1  count clock; one tick per rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 mode  in  1  0 = clock (count up), 1 = timer (count down).
REQ-008 set_en  in  1  adjust mode; counting suspended.
REQ-009 set_sel  in  3  field select while set_en: [0] seconds, [1] minutes, [2] hours.
REQ-010 set_dec  in  1  adjust direction: 0 = increment, 1 = decrement.
REQ-011 preset_load  in  1  load PRESET_H:PRESET_M:PRESET_S.
REQ-012 alarm_en  in  1  enables alarm compare.
REQ-013 alarm_h  in  5  alarm hour.
REQ-014 alarm_m  in  6  alarm minute.
REQ-015 hours  out  5  current hour.
REQ-016 minutes  out  6  current minute.
REQ-017 seconds  out  6  current second.
REQ-018 day_increment  out  1  one-cycle pulse on clock-mode day rollover.
REQ-019 timer_done  out  1  countdown reached zero.
REQ-020 alarm_hit  out  1  one-cycle alarm pulse.
REQ-021 set_led  out  3  registered set_sel & {3{set_en}}.

Function
REQ-022 Priority per edge: preset_load > set_en > mode-dependent counting.
REQ-023 preset_load loads PRESET values, clears timer_done; day_increment and alarm_hit are 0 that cycle.
REQ-024 Set mode: each selected field steps +1 or -1 per edge independently; no carry or borrow between fields.
REQ-025 Set-mode wrap: seconds/minutes 59 <-> 0; hours HOURS_MOD-1 <-> 0.
REQ-026 Clock mode: seconds +1 per edge; 59 -> 0 carries to minutes; minute 59 -> 0 carries to hours; hour HOURS_MOD-1 -> 0.
REQ-027 day_increment = 1 exactly on the edge where HOURS_MOD-1:59:59 becomes 00:00:00, else 0.
REQ-028 Timer mode: decrement per edge; seconds 0 -> 59 borrows from minutes; minutes 0 -> 59 borrows from hours.
REQ-029 Timer mode at 00:00:00: value holds, timer_done = 1 from the next edge onward.
REQ-030 timer_done clears on preset_load, on entering set_en, or when mode = 0.
REQ-031 alarm_hit = 1 for one cycle when alarm_en = 1, mode = 0, set_en = 0, and the counter steps to alarm_h:alarm_m:00.
REQ-032 Alarm values outside legal range never match; there is no error flag.
REQ-033 Outputs are registered; visible one edge after the controlling input is sampled.

Reset
REQ-034 On rst low: hours, minutes, seconds = 0; day_increment, timer_done, alarm_hit = 0; set_led = 0; immediate, clock-independent.
REQ-035 Reset mid-count or mid-set discards all state; counting resumes from 00:00:00 on the first edge after release.

Structure
REQ-036 Package time_pkg holds field widths (5/6/6), SEC_MOD = 60, MIN_MOD = 60, and the mode encoding constants.
REQ-037 Sub-module mod_n_field: one wrapping up/down counter with enable, load, modulus parameter, and carry/borrow out; instantiated three times.

Verification
REQ-038 Reset, mode = 0, 86400 edges -> 00:00:00; day_increment high exactly once, on the final edge.
REQ-039 preset_load, then 10 edges in mode 0 -> 00:00:00; day_increment pulses on edge 10.
REQ-040 Load 00:01:00, mode = 1, 60 edges -> 00:00:00; timer_done rises the next edge and holds at 00:00:00.
REQ-041 set_en, set_sel = 3'b100, set_dec = 1 from hour 0 -> hour 23; set_led = 100; minutes and seconds unchanged.
REQ-042 alarm 00:01, alarm_en, count from 00:00:58 -> alarm_hit high only on the 00:01:00 edge.
REQ-043 Assert rst low mid-cycle during timer countdown -> all outputs 0 immediately, without a clock edge.
